alarm_ring_ctrl: RTL and testbench
==================================

ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter RING_SECS, default 60, ring duration in one_second pulses before auto-stop.
REQ-002 Parameter SNOOZE_SECS, default 300, snooze duration in one_second pulses.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 Reset reset, asynchronous, active-high; clock clock.
REQ-005 clock  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 one_second  input  1  single-cycle pulse, once per second.
REQ-008 alarm_on  input  1  level, alarm armed.
REQ-009 cur_time  input  16  current time, 4 BCD digits HH:MM (hour-tens in [15:12]).
REQ-010 alarm_time  input  16  stored alarm time, same format.
REQ-011 snooze_button  input  1  level, snooze request.
REQ-012 stop_button  input  1  level, stop request.
REQ-013 sound_alarm  output  1  buzzer enable.
REQ-014 snooze_active  output  1  snooze in progress.
REQ-015 snooze_left  output  2  remaining snoozes for current event.

Function
REQ-016 match is combinational: cur_time == alarm_time, all 16 bits.
REQ-017 FSM states IDLE, RINGING, SNOOZE, DONE; registered state, Moore outputs.
REQ-018 IDLE: alarm_on && match -> RINGING; else stay.
REQ-019 RINGING: priority stop_button or !alarm_on -> DONE; then snooze_button && snooze_left!=0 -> SNOOZE; then one_second && ring_cnt==RING_SECS-1 -> DONE; else stay.
REQ-020 SNOOZE: stop_button or !alarm_on -> DONE; one_second && snz_cnt==SNOOZE_SECS-1 -> RINGING; else stay.
REQ-021 DONE: !match -> IDLE; else stay (no retrigger within the matching minute).
REQ-022 ring_cnt cleared whenever state != RINGING, increments on one_second in RINGING.
REQ-023 snz_cnt cleared whenever state != SNOOZE, increments on one_second in SNOOZE.
REQ-024 snooze_left loads MAX_SNOOZE on IDLE->RINGING, decrements by 1 on RINGING->SNOOZE, never wraps below 0.
REQ-025 sound_alarm = (state==RINGING); snooze_active = (state==SNOOZE); snooze_left registered value.
REQ-026 Output latency: one clock from triggering input to output change.
REQ-027 snooze_button held on SNOOZE->RINGING re-entry is a new request only if snooze_left!=0.
REQ-028 one_second coincident with stop_button: stop wins.

Reset
REQ-029 On reset: state IDLE, ring_cnt 0, snz_cnt 0, sound_alarm 0, snooze_active 0, snooze_left 0.
REQ-030 Reset asserted mid-ring or mid-snooze aborts immediately; after release an existing match retriggers RINGING only if alarm_on.

Configuration
REQ-031 Macro ALARM_SNOOZE_EN defined: snooze behaviour per REQ-019/020/024.
REQ-032 Macro ALARM_SNOOZE_EN undefined: snooze_button ignored, SNOOZE unreachable, snooze_active and snooze_left tied 0, snz_cnt not implemented.

Verification
REQ-033 alarm_time=0x0715, cur_time 0x0714->0x0715, alarm_on=1 -> sound_alarm=1 one clock later.
REQ-034 Ringing, no buttons, 60 one_second pulses -> sound_alarm=0 after 60th, state DONE until cur_time=0x0716, then IDLE.
REQ-035 Ringing, snooze_button -> snooze_active=1, snooze_left 3->2; 300 pulses later sound_alarm=1 again.
REQ-036 Three snoozes consumed, fourth snooze_button -> ignored, sound_alarm stays 1, snooze_left=0.
REQ-037 Ringing, stop_button and snooze_button same cycle -> DONE, sound_alarm=0, snooze_left unchanged.
REQ-038 Reset pulse during SNOOZE with match still true and alarm_on=1 -> outputs 0, RINGING one clock after reset release.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: rings on time match, auto-stops after RING_SECS, optional snooze.
// Snooze support is compiled in only when macro ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        one_second,
    input  logic        alarm_on,
    input  logic [15:0] cur_time,
    input  logic [15:0] alarm_time,
    input  logic        snooze_button,
    input  logic        stop_button,
    output logic        sound_alarm,
    output logic        snooze_active,
    output logic [1:0]  snooze_left
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int           RW        = $clog2(RING_SECS + 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [RW-1:0]  r_ring_cnt;
    logic           r_sound_alarm;
    logic           w_match;
    logic           w_snooze_req;

    assign w_match     = (cur_time == alarm_time);
    assign sound_alarm = r_sound_alarm;

`ifdef ALARM_SNOOZE_EN
    localparam int            SW       = $clog2(SNOOZE_SECS + 1);
    localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECS - 1);

    logic [SW-1:0]  r_snz_cnt;
    logic [1:0]     r_snooze_left;
    logic           r_snooze_active;

    assign w_snooze_req  = snooze_button && (r_snooze_left != 2'd0);
    assign snooze_active = r_snooze_active;
    assign snooze_left   = r_snooze_left;
`else
    logic w_unused_snooze;

    assign w_unused_snooze = snooze_button;
    assign w_snooze_req    = 1'b0;
    assign snooze_active   = 1'b0;
    assign snooze_left     = 2'd0;
`endif

    // Next-state decode; stop and disarm take priority over snooze and timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (alarm_on && w_match) w_state_nxt = RINGING;
                else                     w_state_nxt = IDLE;
            end
            RINGING: begin
                if (stop_button || !alarm_on)                     w_state_nxt = DONE;
                else if (w_snooze_req)                            w_state_nxt = SNOOZE;
                else if (one_second && (r_ring_cnt == RING_LAST)) w_state_nxt = DONE;
                else                                              w_state_nxt = RINGING;
            end
            SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                if (stop_button || !alarm_on)                    w_state_nxt = DONE;
                else if (one_second && (r_snz_cnt == SNZ_LAST))  w_state_nxt = RINGING;
                else                                             w_state_nxt = SNOOZE;
`else
                w_state_nxt = DONE;
`endif
            end
            DONE: begin
                if (!w_match) w_state_nxt = IDLE;
                else          w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and buzzer output, both updated from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sound_alarm <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sound_alarm <= (w_state_nxt == RINGING);
        end
    end

    // Ring duration counter, live only while ringing
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   r_ring_cnt <= '0;
        else if (r_state != RINGING) r_ring_cnt <= '0;
        else if (one_second)         r_ring_cnt <= r_ring_cnt + RW'(1);
        else                         r_ring_cnt <= r_ring_cnt;
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze duration counter, live only while snoozing
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  r_snz_cnt <= '0;
        else if (r_state != SNOOZE) r_snz_cnt <= '0;
        else if (one_second)        r_snz_cnt <= r_snz_cnt + SW'(1);
        else                        r_snz_cnt <= r_snz_cnt;
    end

    // Snooze budget per alarm event and snooze indicator
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_snooze_left   <= 2'd0;
            r_snooze_active <= 1'b0;
        end else begin
            r_snooze_active <= (w_state_nxt == SNOOZE);
            if ((r_state == IDLE) && (w_state_nxt == RINGING))
                r_snooze_left <= 2'(MAX_SNOOZE);
            else if ((r_state == RINGING) && (w_state_nxt == SNOOZE) && (r_snooze_left != 2'd0))
                r_snooze_left <= r_snooze_left - 2'd1;
            else
                r_snooze_left <= r_snooze_left;
        end
    end
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl; snooze scenarios run when ALARM_SNOOZE_EN is defined.
module tb_alarm_ring_ctrl;

    logic        clock;
    logic        reset;
    logic        one_second;
    logic        alarm_on;
    logic [15:0] cur_time;
    logic [15:0] alarm_time;
    logic        snooze_button;
    logic        stop_button;
    logic        sound_alarm;
    logic        snooze_active;
    logic [1:0]  snooze_left;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] EXP_LEFT = 2'd3;
`else
    localparam logic [1:0] EXP_LEFT = 2'd0;
`endif

    alarm_ring_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .alarm_on      (alarm_on),
        .cur_time      (cur_time),
        .alarm_time    (alarm_time),
        .snooze_button (snooze_button),
        .stop_button   (stop_button),
        .sound_alarm   (sound_alarm),
        .snooze_active (snooze_active),
        .snooze_left   (snooze_left)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_sec(input int n);
        for (int i = 0; i < n; i++) begin
            one_second = 1'b1;
            tick();
            one_second = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({sound_alarm, snooze_active, snooze_left} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b exp 0000", {sound_alarm, snooze_active, snooze_left});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_trigger();
        alarm_time = 16'h0715;
        cur_time   = 16'h0714;
        alarm_on   = 1'b1;
        tick();
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_before_match: got %b exp 0", sound_alarm);
        end
        cur_time = 16'h0715;
        tick();
        n_checks++;
        if (sound_alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL trig_sound: got %b exp 1", sound_alarm);
        end
        n_checks++;
        if (snooze_left !== EXP_LEFT) begin
            n_fail++;
            $display("FAIL trig_left: got %0d exp %0d", snooze_left, EXP_LEFT);
        end
    endtask

    task automatic test_auto_stop();
        pulse_sec(59);
        n_checks++;
        if (sound_alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_59: got %b exp 1", sound_alarm);
        end
        pulse_sec(1);
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_60: got %b exp 0", sound_alarm);
        end
        tick(); tick(); tick();
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL done_no_retrig: got %b exp 0", sound_alarm);
        end
        cur_time = 16'h0716;
        tick();
        cur_time = 16'h0715;
        tick();
        n_checks++;
        if (sound_alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_retrig: got %b exp 1", sound_alarm);
        end
        alarm_on = 1'b0;
        tick();
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL disarm_stop: got %b exp 0", sound_alarm);
        end
        alarm_on = 1'b1;
        tick();
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_in_done: got %b exp 0", sound_alarm);
        end
        cur_time = 16'h0716;
        tick();
    endtask

    task automatic test_stop_with_snooze();
        cur_time = 16'h0715;
        tick();
        stop_button   = 1'b1;
        snooze_button = 1'b1;
        one_second    = 1'b1;
        tick();
        stop_button   = 1'b0;
        snooze_button = 1'b0;
        one_second    = 1'b0;
        n_checks++;
        if ({sound_alarm, snooze_active} !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_outputs: got %b exp 00", {sound_alarm, snooze_active});
        end
        n_checks++;
        if (snooze_left !== EXP_LEFT) begin
            n_fail++;
            $display("FAIL stop_left: got %0d exp %0d", snooze_left, EXP_LEFT);
        end
        cur_time = 16'h0716;
        tick();
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        cur_time = 16'h0715;
        tick();
        snooze_button = 1'b1;
        tick();
        snooze_button = 1'b0;
        n_checks++;
        if ({sound_alarm, snooze_active, snooze_left} !== 4'b0110) begin
            n_fail++;
            $display("FAIL snz1_enter: got %b exp 0110", {sound_alarm, snooze_active, snooze_left});
        end
        pulse_sec(299);
        n_checks++;
        if (snooze_active !== 1'b1) begin
            n_fail++;
            $display("FAIL snz1_299: got %b exp 1", snooze_active);
        end
        pulse_sec(1);
        n_checks++;
        if ({sound_alarm, snooze_active} !== 2'b10) begin
            n_fail++;
            $display("FAIL snz1_resume: got %b exp 10", {sound_alarm, snooze_active});
        end
        snooze_button = 1'b1;
        tick();
        n_checks++;
        if (snooze_left !== 2'd1) begin
            n_fail++;
            $display("FAIL snz2_left: got %0d exp 1", snooze_left);
        end
        pulse_sec(300);
        n_checks++;
        if ({snooze_active, snooze_left} !== 3'b100) begin
            n_fail++;
            $display("FAIL snz3_held_reentry: got %b exp 100", {snooze_active, snooze_left});
        end
        pulse_sec(300);
        n_checks++;
        if ({sound_alarm, snooze_active, snooze_left} !== 4'b1000) begin
            n_fail++;
            $display("FAIL snz4_ignored: got %b exp 1000", {sound_alarm, snooze_active, snooze_left});
        end
        snooze_button = 1'b0;
        stop_button   = 1'b1;
        tick();
        stop_button = 1'b0;
        cur_time    = 16'h0716;
        tick();
    endtask
`else
    task automatic test_snooze_disabled();
        cur_time = 16'h0715;
        tick();
        snooze_button = 1'b1;
        tick(); tick();
        n_checks++;
        if ({sound_alarm, snooze_active, snooze_left} !== 4'b1000) begin
            n_fail++;
            $display("FAIL snz_ignored: got %b exp 1000", {sound_alarm, snooze_active, snooze_left});
        end
        snooze_button = 1'b0;
        stop_button   = 1'b1;
        tick();
        stop_button = 1'b0;
        cur_time    = 16'h0716;
        tick();
    endtask
`endif

    task automatic test_reset_mid_event();
        cur_time = 16'h0715;
        tick();
`ifdef ALARM_SNOOZE_EN
        snooze_button = 1'b1;
        tick();
        snooze_button = 1'b0;
`endif
        pulse_sec(5);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({sound_alarm, snooze_active, snooze_left} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_abort: got %b exp 0000", {sound_alarm, snooze_active, snooze_left});
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({sound_alarm, snooze_left} !== {1'b1, EXP_LEFT}) begin
            n_fail++;
            $display("FAIL reset_retrig: got %b exp %b", {sound_alarm, snooze_left}, {1'b1, EXP_LEFT});
        end
        alarm_on = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_disarmed: got %b exp 0", sound_alarm);
        end
    endtask

    initial begin
        reset         = 1'b1;
        one_second    = 1'b0;
        alarm_on      = 1'b0;
        cur_time      = 16'h0000;
        alarm_time    = 16'h0715;
        snooze_button = 1'b0;
        stop_button   = 1'b0;
        test_reset();
        test_trigger();
        test_auto_stop();
        test_stop_with_snooze();
`ifdef ALARM_SNOOZE_EN
        test_snooze();
`else
        test_snooze_disabled();
`endif
        test_reset_mid_event();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
